// File: rtl/bullcow_game_param_if.sv
// Signal bundle between the input conditioning, the bullcow_game_param engine
// and the display/score drivers.
// master: the input side (drives enter and sw, observes the game outputs).
// slave : the game engine (samples enter and sw, drives every game output).
// Entry protocol: enter is a level; the engine acts once per 0->1 transition
// of enter. sw must be stable in the cycle that transition is sampled.
interface bullcow_game_param_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4,
   parameter int SCORE_W = 8
);
   localparam int CNT_W = $clog2(DIGITS + 1);

   logic                      enter;
   logic [DIGITS*DIGIT_W-1:0] sw;
   logic [CNT_W-1:0]          bull_count;
   logic [CNT_W-1:0]          cow_count;
   logic [2:0]                game_state;
   logic                      invalid;
   logic [1:0]                winner;
   logic [SCORE_W-1:0]        p1_points;
   logic [SCORE_W-1:0]        p2_points;

   modport master (
      output enter, sw,
      input  bull_count, cow_count, game_state, invalid, winner, p1_points, p2_points
   );

   modport slave (
      input  enter, sw,
      output bull_count, cow_count, game_state, invalid, winner, p1_points, p2_points
   );
endinterface

// File: rtl/bullcow_game_param.sv
// Parametrised Bulls-and-Cows two-player game engine.
// Both players first enter a secret (SETUP1, SETUP2). They then take turns
// guessing the other player's secret (GUESS1, GUESS2) until one of them
// scores DIGITS bulls. The state register is visible on game_state.
// Optional feature macro: BULLCOW_ROUND_LIMIT_EN. When it is defined, the game
// ends in a draw after MAX_ROUNDS complete rounds with no winner.
module bullcow_game_param #(
   parameter int DIGITS     = 4,
   parameter int DIGIT_W    = 4,
   parameter int BASE       = 10,
   parameter int SCORE_W    = 8,
   parameter int MAX_ROUNDS = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   bullcow_game_param_if.slave   bus
);
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int SW_W  = DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      ST_SETUP1 = 3'b000,
      ST_SETUP2 = 3'b001,
      ST_GUESS1 = 3'b010,
      ST_GUESS2 = 3'b011,
      ST_END    = 3'b111
   } state_t;

   state_t             state_q, state_n;
   logic               enter_d;
   logic [SW_W-1:0]    secret1_q, secret1_n;
   logic [SW_W-1:0]    secret2_q, secret2_n;
   logic [CNT_W-1:0]   bull_q, bull_n;
   logic [CNT_W-1:0]   cow_q, cow_n;
   logic               invalid_q, invalid_n;
   logic [1:0]         winner_q, winner_n;
   logic [SCORE_W-1:0] p1_q, p1_n;
   logic [SCORE_W-1:0] p2_q, p2_n;

   logic               entry_event;
   logic               entry_valid;
   logic [SW_W-1:0]    target;
   logic [CNT_W-1:0]   bulls;
   logic [CNT_W-1:0]   cows;
   logic               cow_hit;
   logic               all_bulls;

`ifdef BULLCOW_ROUND_LIMIT_EN
   localparam int RND_W = $clog2(MAX_ROUNDS + 1);
   logic [RND_W-1:0] round_q, round_n, round_inc;
`endif

   // A held button yields one event: only the rising edge of enter counts.
   assign entry_event = bus.enter & ~enter_d;

   // Entry is valid when every digit is below BASE and all digits differ.
   always_comb begin
      entry_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (int'(bus.sw[i*DIGIT_W +: DIGIT_W]) >= BASE) begin
            entry_valid = 1'b0;
         end
         for (int j = i + 1; j < DIGITS; j++) begin
            if (bus.sw[i*DIGIT_W +: DIGIT_W] == bus.sw[j*DIGIT_W +: DIGIT_W]) begin
               entry_valid = 1'b0;
            end
         end
      end
   end

   // Score the live sw against the opponent's secret (P1 guesses secret2).
   always_comb begin
      target  = (state_q == ST_GUESS1) ? secret2_q : secret1_q;
      bulls   = '0;
      cows    = '0;
      cow_hit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         cow_hit = 1'b0;
         if (bus.sw[i*DIGIT_W +: DIGIT_W] == target[i*DIGIT_W +: DIGIT_W]) begin
            bulls = bulls + CNT_W'(1);
         end else begin
            for (int j = 0; j < DIGITS; j++) begin
               if ((j != i) &&
                   (bus.sw[i*DIGIT_W +: DIGIT_W] == target[j*DIGIT_W +: DIGIT_W])) begin
                  cow_hit = 1'b1;
               end
            end
            if (cow_hit) begin
               cows = cows + CNT_W'(1);
            end
         end
      end
      all_bulls = (int'(bulls) == DIGITS);
   end

   // Next-state and next-output logic; every register holds unless an event acts.
   always_comb begin
      state_n   = state_q;
      secret1_n = secret1_q;
      secret2_n = secret2_q;
      bull_n    = bull_q;
      cow_n     = cow_q;
      invalid_n = invalid_q;
      winner_n  = winner_q;
      p1_n      = p1_q;
      p2_n      = p2_q;
`ifdef BULLCOW_ROUND_LIMIT_EN
      round_n   = round_q;
      round_inc = round_q + RND_W'(1);
`endif
      case (state_q)
         ST_SETUP1: begin
            if (entry_event) begin
               if (entry_valid) begin
                  secret1_n = bus.sw;
                  invalid_n = 1'b0;
                  state_n   = ST_SETUP2;
               end else begin
                  invalid_n = 1'b1;
               end
            end
         end
         ST_SETUP2: begin
            if (entry_event) begin
               if (entry_valid) begin
                  secret2_n = bus.sw;
                  invalid_n = 1'b0;
                  bull_n    = '0;
                  cow_n     = '0;
`ifdef BULLCOW_ROUND_LIMIT_EN
                  round_n   = '0;
`endif
                  state_n   = ST_GUESS1;
               end else begin
                  invalid_n = 1'b1;
               end
            end
         end
         ST_GUESS1: begin
            if (entry_event) begin
               if (entry_valid) begin
                  invalid_n = 1'b0;
                  bull_n    = bulls;
                  cow_n     = cows;
                  if (all_bulls) begin
                     if (p1_q != {SCORE_W{1'b1}}) begin
                        p1_n = p1_q + SCORE_W'(1);
                     end
                     winner_n = 2'b01;
                     state_n  = ST_END;
                  end else begin
                     state_n = ST_GUESS2;
                  end
               end else begin
                  invalid_n = 1'b1;
               end
            end
         end
         ST_GUESS2: begin
            if (entry_event) begin
               if (entry_valid) begin
                  invalid_n = 1'b0;
                  bull_n    = bulls;
                  cow_n     = cows;
                  if (all_bulls) begin
                     if (p2_q != {SCORE_W{1'b1}}) begin
                        p2_n = p2_q + SCORE_W'(1);
                     end
                     winner_n = 2'b10;
                     state_n  = ST_END;
                  end else begin
                     state_n = ST_GUESS1;
`ifdef BULLCOW_ROUND_LIMIT_EN
                     // A miss closes the round; the last allowed round ends in a draw.
                     round_n = round_inc;
                     if (int'(round_inc) == MAX_ROUNDS) begin
                        winner_n = 2'b11;
                        state_n  = ST_END;
                     end
`endif
                  end
               end else begin
                  invalid_n = 1'b1;
               end
            end
         end
         ST_END: begin
            // Any press starts a new game; sw is not looked at, scores are kept.
            if (entry_event) begin
               secret1_n = '0;
               secret2_n = '0;
               bull_n    = '0;
               cow_n     = '0;
               winner_n  = 2'b00;
               invalid_n = 1'b0;
`ifdef BULLCOW_ROUND_LIMIT_EN
               round_n   = '0;
`endif
               state_n   = ST_SETUP1;
            end
         end
         default: begin
            state_n = ST_SETUP1;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_SETUP1;
         enter_d   <= 1'b0;
         secret1_q <= '0;
         secret2_q <= '0;
         bull_q    <= '0;
         cow_q     <= '0;
         invalid_q <= 1'b0;
         winner_q  <= 2'b00;
         p1_q      <= '0;
         p2_q      <= '0;
      end else begin
         state_q   <= state_n;
         enter_d   <= bus.enter;
         secret1_q <= secret1_n;
         secret2_q <= secret2_n;
         bull_q    <= bull_n;
         cow_q     <= cow_n;
         invalid_q <= invalid_n;
         winner_q  <= winner_n;
         p1_q      <= p1_n;
         p2_q      <= p2_n;
      end
   end

`ifdef BULLCOW_ROUND_LIMIT_EN
   // Completed-round counter used for the draw limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         round_q <= '0;
      end else begin
         round_q <= round_n;
      end
   end
`endif

   assign bus.game_state = state_q;
   assign bus.bull_count = bull_q;
   assign bus.cow_count  = cow_q;
   assign bus.invalid    = invalid_q;
   assign bus.winner     = winner_q;
   assign bus.p1_points  = p1_q;
   assign bus.p2_points  = p2_q;
endmodule

// File: tb/tb_bullcow_game_param.sv
// Bench for bullcow_game_param (DIGITS=4, DIGIT_W=4, BASE=10, SCORE_W=8,
// MAX_ROUNDS=2). A table of presses with expected outputs, then hand-written
// sequences for held enter, score saturation, async reset and the round limit.
module tb_bullcow_game_param;
   logic clock;
   logic reset;

   int checks = 0;
   int errors = 0;

   bullcow_game_param_if #(.DIGITS(4), .DIGIT_W(4), .SCORE_W(8)) bus ();

   bullcow_game_param #(
      .DIGITS(4), .DIGIT_W(4), .BASE(10), .SCORE_W(8), .MAX_ROUNDS(2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock: period 10, rising edge active; outputs are sampled on falling edges.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] sw;
      logic [2:0]  st;
      logic [2:0]  bull;
      logic [2:0]  cow;
      logic        inv;
      logic [1:0]  win;
      logic [7:0]  p1;
      logic [7:0]  p2;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] bull,
                            input logic [2:0] cow, input logic inv, input logic [1:0] win,
                            input logic [7:0] p1, input logic [7:0] p2);
      check({tag, "_state"},   32'(bus.game_state), 32'(st));
      check({tag, "_bull"},    32'(bus.bull_count), 32'(bull));
      check({tag, "_cow"},     32'(bus.cow_count),  32'(cow));
      check({tag, "_invalid"}, 32'(bus.invalid),    32'(inv));
      check({tag, "_winner"},  32'(bus.winner),     32'(win));
      check({tag, "_p1"},      32'(bus.p1_points),  32'(p1));
      check({tag, "_p2"},      32'(bus.p2_points),  32'(p2));
   endtask

   task automatic do_reset();
      bus.enter = 1'b0;
      bus.sw    = 16'h0000;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // One press: enter high for one cycle, returns at the sampling falling edge.
   task automatic press(input logic [15:0] v);
      @(negedge clock);
      bus.sw    = v;
      bus.enter = 1'b1;
      @(negedge clock);
      bus.enter = 1'b0;
   endtask

   // A full game that P1 wins on the first guess, then back to SETUP1.
   task automatic p1_quick_win();
      press(16'h1234);
      press(16'h5678);
      press(16'h5678);
      press(16'h0000);
   endtask

   initial begin
      //            sw        st    bull  cow   inv win    p1     p2
      vecs[0]  = '{16'h1123, 3'd0, 3'd0, 3'd0, 1'b1, 2'd0, 8'd0, 8'd0};
      vecs[1]  = '{16'h1A23, 3'd0, 3'd0, 3'd0, 1'b1, 2'd0, 8'd0, 8'd0};
      vecs[2]  = '{16'h1234, 3'd1, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0};
      vecs[3]  = '{16'h5678, 3'd2, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0};
      vecs[4]  = '{16'h8675, 3'd3, 3'd2, 3'd2, 1'b0, 2'd0, 8'd0, 8'd0};
      vecs[5]  = '{16'h9012, 3'd2, 3'd0, 3'd2, 1'b0, 2'd0, 8'd0, 8'd0};
      vecs[6]  = '{16'h5678, 3'd7, 3'd4, 3'd0, 1'b0, 2'd1, 8'd1, 8'd0};
      vecs[7]  = '{16'h1123, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1, 8'd0};
      vecs[8]  = '{16'h2345, 3'd1, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1, 8'd0};
      vecs[9]  = '{16'h6789, 3'd2, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1, 8'd0};
      vecs[10] = '{16'h1111, 3'd2, 3'd0, 3'd0, 1'b1, 2'd0, 8'd1, 8'd0};
      vecs[11] = '{16'h9876, 3'd3, 3'd0, 3'd4, 1'b0, 2'd0, 8'd1, 8'd0};
      vecs[12] = '{16'h2345, 3'd7, 3'd4, 3'd0, 1'b0, 2'd2, 8'd1, 8'd1};
      vecs[13] = '{16'h0000, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1, 8'd1};

      do_reset();
      check_all("reset", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);

      // Table of single presses from reset.
      for (int k = 0; k < 14; k++) begin
         press(vecs[k].sw);
         check_all($sformatf("v%0d", k), vecs[k].st, vecs[k].bull, vecs[k].cow,
                   vecs[k].inv, vecs[k].win, vecs[k].p1, vecs[k].p2);
      end

      // Held enter gives exactly one transition.
      do_reset();
      @(negedge clock);
      bus.sw    = 16'h1234;
      bus.enter = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check($sformatf("hold_c%0d_state", c), 32'(bus.game_state), 32'd1);
      end
      bus.enter = 1'b0;
      @(negedge clock);
      check("hold_release_state", 32'(bus.game_state), 32'd1);
      press(16'h5678);
      check("hold_repress_state", 32'(bus.game_state), 32'd2);

      // Score saturation at 255.
      do_reset();
      for (int g = 0; g < 255; g++) p1_quick_win();
      check("sat_p1_255", 32'(bus.p1_points), 32'd255);
      press(16'h1234);
      press(16'h5678);
      press(16'h5678);
      check_all("sat_win", 3'd7, 3'd4, 3'd0, 1'b0, 2'd1, 8'd255, 8'd0);

      // Asynchronous reset in GUESS2 with p1_points=3.
      do_reset();
      for (int g = 0; g < 3; g++) p1_quick_win();
      press(16'h1234);
      press(16'h5678);
      press(16'h1243);
      check_all("pre_rst", 3'd3, 3'd0, 3'd0, 1'b0, 2'd0, 8'd3, 8'd0);
      #2 reset = 1'b1;
      #1;
      check_all("async_rst", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_all("after_rst", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);

      // Two full rounds of misses.
      do_reset();
      press(16'h1234);
      press(16'h5678);
      for (int r = 0; r < 2; r++) begin
         press(16'h1243);
         check($sformatf("rnd%0d_p1miss_state", r), 32'(bus.game_state), 32'd3);
         press(16'h5678);
      end
`ifdef BULLCOW_ROUND_LIMIT_EN
      check_all("draw", 3'd7, 3'd0, 3'd0, 1'b0, 2'd3, 8'd0, 8'd0);
      press(16'h1111);
      check_all("draw_restart", 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);
`else
      check_all("no_limit_r2", 3'd2, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);
      press(16'h1243);
      press(16'h5678);
      check_all("no_limit_r3", 3'd2, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0, 8'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bullcow_game_param.md
# bullcow_game_param

Parametrised Bulls-and-Cows two-player game engine. It supersedes the fixed 4-digit game core. Digit count, digit width, numeric base and score width are all configurable. It adds:
- internal enter edge detection;
- validity checking against the base;
- explicit invalid/winner reporting;
- an optional round limit that ends the game in a draw.

It sits between the switch/button input conditioning and the display/score drivers.

## Interface
Parameters:
- DIGITS, 4, number of digits per secret/guess (2..8)
- DIGIT_W, 4, bits per digit
- BASE, 10, digits must be < BASE (BASE ≤ 2^DIGIT_W)
- SCORE_W, 8, width of each player's score counter
- MAX_ROUNDS, 10, guess rounds before a draw (used only with BULLCOW_ROUND_LIMIT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enter  in  1  entry button, debounced upstream, level signal
- sw  in  DIGITS*DIGIT_W  entered number; digit i = sw[i*DIGIT_W +: DIGIT_W]
- bull_count  out  $clog2(DIGITS+1)  bulls of last accepted guess
- cow_count  out  $clog2(DIGITS+1)  cows of last accepted guess
- game_state  out  3  SETUP1=000, SETUP2=001, GUESS1=010, GUESS2=011, END=111
- invalid  out  1  last entry rejected
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- p1_points  out  SCORE_W  player 1 wins
- p2_points  out  SCORE_W  player 2 wins

## Operation
- An entry event is a 0→1 transition of enter. enter is registered internally (enter_d, reset 0), so event = enter & ~enter_d. Holding enter high produces exactly one event.
- An entry is valid when all DIGITS digits are pairwise distinct and every digit is < BASE.
- Validity and scoring are evaluated combinationally on the current sw, not on a previously latched copy.
- On an invalid entry in any non-END state:
  - invalid←1;
  - state, secrets, bull/cow and scores are unchanged.
- On every valid entry: invalid←0.
- SETUP1: a valid entry loads secret1←sw; state→SETUP2.
- SETUP2: a valid entry loads secret2←sw; state→GUESS1; bull/cow←0; round counter←0.
- GUESS1 (player 1 guesses secret2) and GUESS2 (player 2 guesses secret1). On a valid guess:
  - bulls = count of i with g[i]==s[i];
  - cows = count of i with g[i]!=s[i] such that some j≠i has g[i]==s[j]. Each guess digit counts at most once.
  - bull_count and cow_count are registered.
- If bulls==DIGITS in GUESS1:
  - p1_points increments, saturating at 2^SCORE_W−1;
  - winner←01; state→END.
- GUESS2 wins the same way, updating p2_points and setting winner←10.
- Otherwise GUESS1→GUESS2, and GUESS2→GUESS1. The round counter increments on each GUESS2 miss.
- END: any entry event (sw is ignored; validity is not checked) → SETUP1. This clears secrets, bull/cow, winner, invalid and the round counter. Scores are kept.
- Undefined state encodings → SETUP1 on the next clock.

## Timing
- All outputs are registered and update on the clock edge where the entry event is detected. Latency is 1 cycle from the enter rising edge being sampled.
- Reset values:
  - game_state=000;
  - bull_count=0, cow_count=0;
  - invalid=0;
  - winner=00;
  - p1_points=0, p2_points=0;
  - secrets=0, round counter=0, enter_d=0.
- Reset mid-game is asynchronous and immediate; everything above clears, including scores.
- If enter is already high when reset is released, enter_d is 0, so an event fires on the first clock. Upstream must hold enter low across reset release.
- sw must be stable in the cycle the event is sampled. No other timing constraint applies.
- Score saturation: increments at the maximum value leave the score unchanged. winner and the END transition still occur.

## Configuration
- BULLCOW_ROUND_LIMIT_EN defined:
  - a round counter of width $clog2(MAX_ROUNDS+1) is built;
  - if a GUESS2 miss makes the counter equal MAX_ROUNDS, state→END and winner←11 (draw), with no score change;
  - a winning guess in that same round takes priority (P2 wins).
- BULLCOW_ROUND_LIMIT_EN undefined:
  - no counter logic exists, and rounds are unlimited;
  - winner never takes the value 11.

## Test plan
(DIGITS=4, DIGIT_W=4, BASE=10)
- Reset, then enter sw=16'h1123 → state 000, invalid=1. Then sw=16'h1A23 → invalid=1 (digit ≥ BASE). Then sw=16'h1234 → state 001, invalid=0.
- Hold enter high 5 cycles with a valid sw in SETUP1 → exactly one transition (000→001). State stays 001 until enter is released and pressed again.
- secret2=16'h5678, P1 guesses 16'h8675 → bull=2, cow=2, state 011. Guess 16'h5678 in a later GUESS1 → bull=4, p1_points=1, winner=01, state 111. Next enter → state 000, winner=00, p1_points=1.
- secret1=16'h1234, P2 guesses 16'h9012 → bull=0, cow=2 (the 2 and 1 count; 0 and 9 do not), state 010.
- Assert reset in GUESS2 with p1_points=3 → asynchronously all outputs return to reset values, including p1_points=0.
- With BULLCOW_ROUND_LIMIT_EN and MAX_ROUNDS=2, play 2 full rounds of misses → after the 2nd GUESS2 miss: state 111, winner=11, both scores unchanged.
